// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle datapath controller: state
// encoding, instruction opcodes and the select codes driven onto the
// datapath multiplexers and ALU control.
package multicycle_pkg;

    localparam int StateWidth = 4;

    typedef enum logic [StateWidth-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Primary opcode field values
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath. Sequences each instruction
// through fetch/decode/execute/memory/writeback, stalling in the memory
// access states until MemReady. Outputs decode from the state register;
// only IRWrite/PCWrite in FETCH and IllegalOp in DECODE look at inputs.
// Optional feature: define MC_BNE_EN to execute BNE as a branch; otherwise
// BNE is treated as an illegal opcode and BranchNe is tied low.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int OpWidth   = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [OpWidth-1:0] Opcode,
    input  logic               MemReady,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSrc,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               Branch,
    output logic               BranchNe,
    output logic               IllegalOp,
    output logic [3:0]         StateOut
);

    // The opcode constants are six bits wide and the datapath is assumed to
    // be at least one word; anything else is a mis-instantiation.
    if (OpWidth != 6 || DataWidth < 32) begin : g_param_check
        $error("multicycle_control: unsupported OpWidth/DataWidth");
    end

    state_t state_q;
    state_t state_d;

`ifdef MC_BNE_EN
    // Remembers, across DECODE -> BRANCH, whether the branch is a BNE so the
    // opcode does not need to be looked at again in BRANCH.
    logic is_bne_q;
    logic is_bne_d;
`endif

    // State register; reset parks the machine in FETCH, aborting any
    // instruction in flight before its writeback state is reached.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MC_BNE_EN
    // BNE flag register, updated only while decoding
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            is_bne_q <= 1'b0;
        end else begin
            is_bne_q <= is_bne_d;
        end
    end
`endif

    // Next-state logic and the DECODE-time illegal opcode flag
    always_comb begin
        state_d   = state_q;
        IllegalOp = 1'b0;
`ifdef MC_BNE_EN
        is_bne_d  = is_bne_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
`ifdef MC_BNE_EN
                is_bne_d = (Opcode == OP_BNE);
`endif
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath control decode from the current state; everything defaults
    // to the inactive value and each state raises only what it needs.
    always_comb begin
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REG;
        ALUOp    = ALUOP_ADD;
        PCSrc    = PCSRC_ALU;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        BranchNe = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
`ifdef MC_BNE_EN
                BranchNe = is_bne_q;
`endif
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign StateOut = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. Walks each
// instruction class through its state sequence with hand-derived state
// numbers and control values, including memory stalls, the illegal opcode
// path, BNE (depending on MC_BNE_EN) and a reset landing mid-instruction.
module tb_multicycle_control;

    logic       clk;
    logic       rstN;
    logic [5:0] opcode;
    logic       memReady;
    logic       iorD;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       regDst;
    logic       memToReg;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic       memWrite;
    logic       branch;
    logic       branchNe;
    logic       illegalOp;
    logic [3:0] stateOut;

    int checkCount = 0;
    int errorCount = 0;

    multicycle_control dut (
        .CLK       (clk),
        .RST       (rstN),
        .Opcode    (opcode),
        .MemReady  (memReady),
        .IorD      (iorD),
        .ALUSrcA   (aluSrcA),
        .ALUSrcB   (aluSrcB),
        .ALUOp     (aluOp),
        .PCSrc     (pcSrc),
        .RegDst    (regDst),
        .MemtoReg  (memToReg),
        .IRWrite   (irWrite),
        .PCWrite   (pcWrite),
        .RegWrite  (regWrite),
        .MemWrite  (memWrite),
        .Branch    (branch),
        .BranchNe  (branchNe),
        .IllegalOp (illegalOp),
        .StateOut  (stateOut)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Set the inputs for the coming cycle and let the combinational outputs settle
    task automatic applyStimulus(input logic [5:0] op, input logic ready);
        opcode   = op;
        memReady = ready;
        #1;
    endtask

    // Move past the next rising edge so outputs are sampled away from it
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN     = 1'b0;
        opcode   = 6'b000000;
        memReady = 1'b1;
        #12;

        // Reset held: FETCH outputs with IRWrite/PCWrite following MemReady
        checkOutput("rst_state", int'(stateOut), 0);
        checkOutput("rst_srcb", int'(aluSrcB), 1);
        checkOutput("rst_irwrite", int'(irWrite), 1);
        checkOutput("rst_pcwrite", int'(pcWrite), 1);
        checkOutput("rst_others", int'({iorD, aluSrcA, aluOp, pcSrc, regDst, memToReg,
                                        regWrite, memWrite, branch, branchNe, illegalOp}), 0);
        memReady = 1'b0;
        #1;
        checkOutput("rst_irwrite_low", int'(irWrite), 0);
        checkOutput("rst_pcwrite_low", int'(pcWrite), 0);
        nextCycle();
        checkOutput("rst_hold", int'(stateOut), 0);

        // Release and run LW with no stalls: 0,1,2,3,4,0
        rstN = 1'b1;
        applyStimulus(6'b100011, 1'b1);
        nextCycle();
        checkOutput("lw_decode", int'(stateOut), 1);
        checkOutput("lw_decode_srcb", int'(aluSrcB), 3);
        nextCycle();
        checkOutput("lw_memadr", int'(stateOut), 2);
        checkOutput("lw_memadr_src", int'({aluSrcA, aluSrcB}), 3'b110);
        nextCycle();
        checkOutput("lw_memrd", int'(stateOut), 3);
        checkOutput("lw_memrd_iord", int'(iorD), 1);
        nextCycle();
        checkOutput("lw_memwb", int'(stateOut), 4);
        checkOutput("lw_memwb_wr", int'({memToReg, regWrite}), 2'b11);
        nextCycle();
        checkOutput("lw_done", int'(stateOut), 0);

        // FETCH stall: no IR/PC write and the state holds
        applyStimulus(6'b101011, 1'b0);
        checkOutput("fetch_stall_irw", int'(irWrite), 0);
        nextCycle();
        checkOutput("fetch_stall_state", int'(stateOut), 0);

        // SW with three stalled cycles in MEMWR: MemWrite for four cycles
        applyStimulus(6'b101011, 1'b1);
        nextCycle();
        checkOutput("sw_decode", int'(stateOut), 1);
        nextCycle();
        checkOutput("sw_memadr", int'(stateOut), 2);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'b101011, (i == 3));
            checkOutput("sw_memwr_state", int'(stateOut), 5);
            checkOutput("sw_memwrite", int'({iorD, memWrite}), 2'b11);
            nextCycle();
        end
        checkOutput("sw_done", int'(stateOut), 0);

        // R-type: 0,1,6,7,0
        applyStimulus(6'b000000, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("r_exec", int'(stateOut), 6);
        checkOutput("r_exec_ctl", int'({aluSrcA, aluOp}), 3'b110);
        nextCycle();
        checkOutput("r_aluwb", int'(stateOut), 7);
        checkOutput("r_aluwb_ctl", int'({regDst, regWrite}), 2'b11);
        nextCycle();
        checkOutput("r_done", int'(stateOut), 0);

        // ADDI: 0,1,9,10,0
        applyStimulus(6'b001000, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("addi_ex", int'(stateOut), 9);
        checkOutput("addi_ex_srcb", int'(aluSrcB), 2);
        nextCycle();
        checkOutput("addi_wb", int'(stateOut), 10);
        checkOutput("addi_wb_ctl", int'({regDst, regWrite}), 2'b01);
        nextCycle();
        checkOutput("addi_done", int'(stateOut), 0);

        // Unrecognised opcode: IllegalOp for the DECODE cycle, then FETCH
        applyStimulus(6'b111111, 1'b1);
        checkOutput("ill_fetch_flag", int'(illegalOp), 0);
        nextCycle();
        checkOutput("ill_decode", int'(stateOut), 1);
        checkOutput("ill_flag", int'(illegalOp), 1);
        nextCycle();
        checkOutput("ill_back", int'(stateOut), 0);
        checkOutput("ill_flag_clear", int'(illegalOp), 0);

        // BEQ: 0,1,8,0 with BranchNe low
        applyStimulus(6'b000100, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("beq_branch", int'(stateOut), 8);
        checkOutput("beq_ctl", int'({aluSrcA, aluOp, pcSrc, branch, branchNe}), 7'b1010110);
        nextCycle();
        checkOutput("beq_done", int'(stateOut), 0);

        // BNE: branch when enabled, illegal otherwise
        applyStimulus(6'b000101, 1'b1);
        nextCycle();
`ifdef MC_BNE_EN
        checkOutput("bne_flag", int'(illegalOp), 0);
        nextCycle();
        checkOutput("bne_branch", int'(stateOut), 8);
        checkOutput("bne_ctl", int'({branch, branchNe}), 2'b11);
        nextCycle();
`else
        checkOutput("bne_flag", int'(illegalOp), 1);
        nextCycle();
`endif
        checkOutput("bne_done", int'(stateOut), 0);

        // J: 0,1,11,0
        applyStimulus(6'b000010, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("j_jump", int'(stateOut), 11);
        checkOutput("j_ctl", int'({pcSrc, pcWrite}), 3'b101);
        nextCycle();
        checkOutput("j_done", int'(stateOut), 0);

        // Reset in MEMRD: asynchronous return to FETCH, writeback never seen
        applyStimulus(6'b100011, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("rstmid_memrd", int'(stateOut), 3);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rstmid_async", int'(stateOut), 0);
        checkOutput("rstmid_regwrite", int'(regWrite), 0);
        nextCycle();
        checkOutput("rstmid_hold", int'(stateOut), 0);
        checkOutput("rstmid_regwrite_hold", int'(regWrite), 0);
        rstN = 1'b1;
        nextCycle();
        checkOutput("rstmid_resume", int'(stateOut), 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multicycle datapath. It sequences every instruction through fetch, decode, execute, memory and writeback cycles. It drives the select lines of the datapath's 2:1 and 4:1 operand/PC multiplexers and all register, memory and PC write enables, with outputs decoded from the current state. It stalls in memory-access states until the memory reports ready.

## Interface
- `DataWidth`, 32: datapath width; documentation only, no ports scale with it.
- `OpWidth`, 6: opcode field width.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: asynchronous, active-low reset.
- `Opcode` in OpWidth: instruction opcode from the instruction register.
- `MemReady` in 1: memory has completed the current access.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = register A.
- `ALUSrcB` out 2: ALU B select; 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `PCSrc` out 2: PC source; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `RegDst`, `MemtoReg` out 1 each: write register select and write data select.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` out 1 each: write enables.
- `Branch` out 1: conditional PC write, qualified by Zero in the datapath.
- `BranchNe` out 1: invert Zero for the branch condition.
- `IllegalOp` out 1: one-cycle flag for an unrecognised opcode.
- `StateOut` out 4: current state, for debug.

## Operation
- Opcode encodings:
  - R = 000000
  - LW = 100011
  - SW = 101011
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
  - BNE = 000101
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH goes to DECODE when MemReady = 1; otherwise it holds.
  - DECODE dispatches by opcode: LW/SW to MEMADR, R to EXEC, BEQ (and BNE, see Configuration) to BRANCH, ADDI to ADDIEX, J to JUMP. Any other opcode goes to FETCH with IllegalOp = 1 for that DECODE cycle.
  - MEMADR goes to MEMRD for LW and to MEMWR for SW.
  - MEMRD goes to MEMWB when MemReady = 1; otherwise it holds.
  - MEMWR goes to FETCH when MemReady = 1; otherwise it holds.
  - EXEC goes to ALUWB, and ADDIEX goes to ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.
  - Unused encodings 12–15 go to FETCH.
- Asserted outputs per state. Every output not listed is 0.
  - FETCH: ALUSrcB = 01; IRWrite = PCWrite = MemReady.
  - DECODE: ALUSrcB = 11.
  - MEMADR and ADDIEX: ALUSrcA = 1, ALUSrcB = 10.
  - MEMRD: IorD = 1.
  - MEMWB: MemtoReg = 1, RegWrite = 1.
  - MEMWR: IorD = 1, MemWrite = 1. MemWrite is held for the whole stall.
  - EXEC: ALUSrcA = 1, ALUOp = 10.
  - ALUWB: RegDst = 1, RegWrite = 1.
  - BRANCH: ALUSrcA = 1, ALUOp = 01, PCSrc = 01, Branch = 1. BranchNe = 1 only for BNE.
  - ADDIWB: RegWrite = 1.
  - JUMP: PCSrc = 10, PCWrite = 1.
- Opcode is sampled in DECODE and MEMADR only. It is latched by the instruction register, which is stable because IRWrite = 0 outside FETCH.

## Timing
- Reset, asynchronous on RST = 0, sets the state to FETCH. While reset is held:
  - StateOut = 0.
  - ALUSrcB = 01.
  - IRWrite = PCWrite = MemReady.
  - All other outputs are 0.
- Assertion of RST mid-instruction aborts it immediately. No writeback completes.
- Outputs are combinational from the state register. The only Mealy terms are IRWrite/PCWrite in FETCH and IllegalOp in DECODE.
- Cycles with MemReady = 1 everywhere: R = 4, LW = 5, SW = 4, BEQ/BNE = 3, ADDI = 4, J = 3. Each stalled cycle adds one.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.

## Configuration
- `MC_BNE_EN` defined: DECODE dispatches BNE to BRANCH with BranchNe = 1.
- `MC_BNE_EN` undefined: BNE is illegal and goes to FETCH with IllegalOp = 1. BranchNe is tied to 0.

## Structure
- Package `multicycle_pkg`:
  - State enumeration and its 4-bit width.
  - Opcode constants.
  - ALUSrcB, ALUOp and PCSrc code constants.
- Single module: state register plus next-state logic and output decode. No sub-module.

## Test plan
- Reset: hold RST = 0 with MemReady = 1 → StateOut = 0, ALUSrcB = 01, IRWrite = PCWrite = 1, all others 0. Release → DECODE on the next edge.
- LW with MemReady = 1 → state sequence 0, 1, 2, 3, 4, 0. Cycle at state 4 shows MemtoReg = RegWrite = 1.
- SW with MemReady low for 3 cycles in MEMWR → MemWrite = 1 for 4 cycles, then FETCH.
- R-type and ADDI → ALUWB has RegDst = 1; ADDIWB has RegDst = 0 with ALUSrcB = 10 in the preceding state.
- Opcode 111111 → IllegalOp = 1 for one cycle in DECODE, then FETCH. Opcode 000101 → BRANCH with BranchNe = 1 when `MC_BNE_EN` is defined, IllegalOp = 1 otherwise.
- J, plus RST asserted during MEMRD → JUMP gives PCSrc = 10 and PCWrite = 1; the reset returns to FETCH asynchronously with RegWrite never asserted.
